// File: rtl/ad9361x2_ensm_scheduler.sv
// rtl/ad9361x2_ensm_scheduler.sv - half-duplex RX/TX burst scheduler for the AD9361x2 ENSM pins
// Alternating-priority arbiter followed by a SETUP/ACTIVE/GUARD sequencer with registered pin outputs.
module ad9361x2_ensm_scheduler #(
   parameter int LEN_W        = 16,
   parameter int SETUP_CYCLES = 4,
   parameter int GUARD_CYCLES = 8
) (
   input  logic             axi_aclk,
   input  logic             arst,
   input  logic             rx_valid,
   input  logic [LEN_W-1:0] rx_len,
   input  logic [1:0]       rx_mask,
   output logic             rx_ready,
   output logic             rx_done,
   input  logic             tx_valid,
   input  logic [LEN_W-1:0] tx_len,
   input  logic [1:0]       tx_mask,
   output logic             tx_ready,
   output logic             tx_done,
   input  logic             abort,
   output logic             enable_0,
   output logic             enable_1,
   output logic             txnrx_0,
   output logic             txnrx_1,
   output logic             tdd_sync_o,
   output logic             busy
);
   localparam int SET_W = $clog2(SETUP_CYCLES + 1);
   localparam int GRD_W = $clog2(GUARD_CYCLES + 1);
   localparam int CNT_W = (LEN_W > SET_W) ? ((LEN_W > GRD_W) ? LEN_W : GRD_W)
                                          : ((SET_W > GRD_W) ? SET_W : GRD_W);
   localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP_CYCLES);
   localparam logic [CNT_W-1:0] C_GUARD = CNT_W'(GUARD_CYCLES);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACTIVE = 2'd2,
      S_GUARD  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_prio;
   logic             r_dir;
   logic [1:0]       r_mask;
   logic [LEN_W-1:0] r_len;
   logic [1:0]       r_enable;
   logic [1:0]       r_txnrx;
   logic             r_sync;
   logic             r_rx_done;
   logic             r_tx_done;
   logic             r_busy;

   logic             w_idle;
   logic             w_rx_win;
   logic             w_tx_win;
   logic             w_accept;
   logic             w_req_dir;
   logic [1:0]       w_req_mask;
   logic [LEN_W-1:0] w_req_len;
   logic [LEN_W-1:0] w_req_len_eff;
   logic             w_enter_active;
   logic             w_enter_guard;

   // r_prio = 0 prefers RX, 1 prefers TX; it only matters when both sides request
   assign w_idle   = (r_state == S_IDLE);
   assign w_rx_win = rx_valid & (~tx_valid | ~r_prio);
   assign w_tx_win = tx_valid & (~rx_valid |  r_prio);
   assign rx_ready = w_idle & w_rx_win;
   assign tx_ready = w_idle & w_tx_win;

   assign w_accept      = rx_ready | tx_ready;
   assign w_req_dir     = tx_ready;
   assign w_req_mask    = tx_ready ? tx_mask : rx_mask;
   assign w_req_len     = tx_ready ? tx_len  : rx_len;
   assign w_req_len_eff = (w_req_len == '0) ? LEN_W'(1) : w_req_len;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = C_SETUP;
            end
         end
         S_SETUP: begin
            if (abort) begin
               w_state_nxt = S_GUARD;
               w_cnt_nxt   = C_GUARD;
            end else if (r_cnt <= C_ONE) begin
               w_state_nxt = S_ACTIVE;
               w_cnt_nxt   = CNT_W'(r_len);
            end else begin
               w_cnt_nxt   = r_cnt - C_ONE;
            end
         end
         S_ACTIVE: begin
            if (abort || (r_cnt <= C_ONE)) begin
               w_state_nxt = S_GUARD;
               w_cnt_nxt   = C_GUARD;
            end else begin
               w_cnt_nxt   = r_cnt - C_ONE;
            end
         end
         S_GUARD: begin
            if (r_cnt <= C_ONE) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - C_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_enter_active = (r_state == S_SETUP) & (w_state_nxt == S_ACTIVE);
   assign w_enter_guard  = ((r_state == S_SETUP) | (r_state == S_ACTIVE)) & (w_state_nxt == S_GUARD);

   // Outputs are registered from the next-state decode so they line up with the state they describe
   always_ff @(posedge axi_aclk or posedge arst) begin
      if (arst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_prio    <= 1'b0;
         r_dir     <= 1'b0;
         r_mask    <= 2'b00;
         r_len     <= '0;
         r_enable  <= 2'b00;
         r_txnrx   <= 2'b00;
         r_sync    <= 1'b0;
         r_rx_done <= 1'b0;
         r_tx_done <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_dir   <= w_req_dir;
            r_mask  <= w_req_mask;
            r_len   <= w_req_len_eff;
            r_prio  <= ~w_req_dir;
            r_txnrx <= (r_txnrx & ~w_req_mask) | (w_req_mask & {2{w_req_dir}});
         end
         r_enable  <= (w_state_nxt == S_ACTIVE) ? r_mask : 2'b00;
         r_sync    <= w_enter_active;
         r_rx_done <= w_enter_guard & ~r_dir;
         r_tx_done <= w_enter_guard &  r_dir;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign enable_0   = r_enable[0];
   assign enable_1   = r_enable[1];
   assign txnrx_0    = r_txnrx[0];
   assign txnrx_1    = r_txnrx[1];
   assign tdd_sync_o = r_sync;
   assign rx_done    = r_rx_done;
   assign tx_done    = r_tx_done;
   assign busy       = r_busy;

endmodule

// File: tb/tb_ad9361x2_ensm_scheduler.sv
// tb/tb_ad9361x2_ensm_scheduler.sv - scoreboard bench for the AD9361x2 ENSM burst scheduler
module tb_ad9361x2_ensm_scheduler;
   localparam int LEN_W = 16;
   localparam int S     = 4;
   localparam int G     = 8;

   logic             axi_aclk = 1'b0;
   logic             arst     = 1'b1;
   logic             rx_valid = 1'b0;
   logic [LEN_W-1:0] rx_len   = '0;
   logic [1:0]       rx_mask  = 2'b00;
   logic             tx_valid = 1'b0;
   logic [LEN_W-1:0] tx_len   = '0;
   logic [1:0]       tx_mask  = 2'b00;
   logic             abort    = 1'b0;
   logic rx_ready, rx_done, tx_ready, tx_done;
   logic enable_0, enable_1, txnrx_0, txnrx_1, tdd_sync_o, busy;

   ad9361x2_ensm_scheduler #(.LEN_W(LEN_W), .SETUP_CYCLES(S), .GUARD_CYCLES(G)) dut (
      .axi_aclk(axi_aclk), .arst(arst),
      .rx_valid(rx_valid), .rx_len(rx_len), .rx_mask(rx_mask), .rx_ready(rx_ready), .rx_done(rx_done),
      .tx_valid(tx_valid), .tx_len(tx_len), .tx_mask(tx_mask), .tx_ready(tx_ready), .tx_done(tx_done),
      .abort(abort), .enable_0(enable_0), .enable_1(enable_1), .txnrx_0(txnrx_0), .txnrx_1(txnrx_1),
      .tdd_sync_o(tdd_sync_o), .busy(busy)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct {
      bit       dir;
      bit [1:0] mask;
      int       len;
      bit [1:0] txnrx;
   } exp_t;

   exp_t     q[$];
   int       vectors     = 0;
   int       miscompares = 0;
   int       cyc         = 0;
   bit       b_prio      = 1'b0;
   bit [1:0] b_txnrx     = 2'b00;

   bit       trk = 1'b0;
   bit       acc_dir;
   int       t0, sync_t, n_sync, en_first, en_cnt, done_t, n_done, tx_bad;
   bit       done_rx, done_tx;
   bit [1:0] en_or, tx_at1, tx_at_sync, prev_tx;

   always @(posedge axi_aclk) cyc <= cyc + 1;

   // Burst monitor: measures each burst from accept to busy falling, then checks against the queue head
   always @(negedge axi_aclk) begin
      exp_t     e;
      bit [1:0] en, tn;
      int       exp_en_cnt, exp_first;
      en = {enable_1, enable_0};
      tn = {txnrx_1, txnrx_0};
      if (arst) begin
         trk = 1'b0;
      end else begin
         if (trk) begin
            if (cyc == t0 + 1) tx_at1 = tn;
            if (tdd_sync_o) begin
               n_sync++;
               if (sync_t < 0) begin sync_t = cyc; tx_at_sync = tn; end
            end
            if (en != 2'b00) begin
               en_cnt++;
               en_or |= en;
               if (en_first < 0) en_first = cyc;
               if (tn != prev_tx) tx_bad++;
            end
            if (rx_done || tx_done) begin
               n_done++;
               if (done_t < 0) done_t = cyc;
               done_rx |= rx_done;
               done_tx |= tx_done;
            end
            if (!busy && cyc > t0) begin
               trk = 1'b0;
               if (q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_burst: accepted at cycle %0d, scoreboard empty", t0);
               end else begin
                  e = q.pop_front();
                  exp_en_cnt = (e.mask != 2'b00) ? e.len : 0;
                  exp_first  = (e.mask != 2'b00) ? t0 + S + 1 : -1;
                  vectors++;
                  if (acc_dir !== e.dir) begin
                     miscompares++;
                     $display("FAIL grant_dir: got %0d expected %0d (t0=%0d)", acc_dir, e.dir, t0);
                  end
                  vectors++;
                  if ({tx_at1, tx_at_sync} !== {e.txnrx, e.txnrx}) begin
                     miscompares++;
                     $display("FAIL txnrx: setup %b sync %b expected %b (t0=%0d)", tx_at1, tx_at_sync, e.txnrx, t0);
                  end
                  vectors++;
                  if (sync_t !== t0 + S + 1 || n_sync !== 1) begin
                     miscompares++;
                     $display("FAIL tdd_sync: at %0d count %0d expected at %0d count 1", sync_t, n_sync, t0 + S + 1);
                  end
                  vectors++;
                  if (en_cnt !== exp_en_cnt || en_or !== e.mask || en_first !== exp_first) begin
                     miscompares++;
                     $display("FAIL enable: cycles %0d pins %b first %0d expected %0d %b %0d",
                              en_cnt, en_or, en_first, exp_en_cnt, e.mask, exp_first);
                  end
                  vectors++;
                  if (done_t !== t0 + S + e.len + 1 || n_done !== 1 || done_rx !== !e.dir || done_tx !== e.dir) begin
                     miscompares++;
                     $display("FAIL done: at %0d count %0d rx %0d tx %0d expected at %0d dir %0d",
                              done_t, n_done, done_rx, done_tx, t0 + S + e.len + 1, e.dir);
                  end
                  vectors++;
                  if (cyc !== t0 + S + e.len + G + 1) begin
                     miscompares++;
                     $display("FAIL idle: busy fell at %0d expected %0d", cyc, t0 + S + e.len + G + 1);
                  end
                  vectors++;
                  if (tx_bad !== 0) begin
                     miscompares++;
                     $display("FAIL txnrx_stable: %0d changes while enabled, expected 0", tx_bad);
                  end
               end
            end
         end
         if (!trk && ((rx_valid && rx_ready) || (tx_valid && tx_ready))) begin
            trk = 1'b1; t0 = cyc; acc_dir = tx_valid && tx_ready;
            sync_t = -1; n_sync = 0; en_first = -1; en_cnt = 0; done_t = -1; n_done = 0;
            tx_bad = 0; done_rx = 1'b0; done_tx = 1'b0; en_or = 2'b00;
            tx_at1 = 2'b00; tx_at_sync = 2'b00;
         end
      end
      prev_tx = tn;
   end

   task automatic push(input bit dir, input bit [1:0] mask, input int eff);
      exp_t e;
      for (int i = 0; i < 2; i++) if (mask[i]) b_txnrx[i] = dir;
      e.dir = dir; e.mask = mask; e.len = eff; e.txnrx = b_txnrx;
      q.push_back(e);
      b_prio = ~dir;
   endtask

   task automatic send(input bit dir, input bit [1:0] mask, input logic [LEN_W-1:0] len,
                       input int eff, output bit ok);
      push(dir, mask, eff);
      @(posedge axi_aclk); #1;
      if (dir) begin tx_len = len; tx_mask = mask; tx_valid = 1'b1; end
      else     begin rx_len = len; rx_mask = mask; rx_valid = 1'b1; end
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge axi_aclk);
         if ((dir && tx_ready) || (!dir && rx_ready)) begin ok = 1'b1; break; end
      end
      @(posedge axi_aclk); #1;
      rx_valid = 1'b0; tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge axi_aclk); #1;
         if (!trk && q.size() == 0 && !busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_sync(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge axi_aclk);
         if (tdd_sync_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge axi_aclk);
      #1;
      vectors++;
      if ({enable_1, enable_0, txnrx_1, txnrx_0, tdd_sync_o, rx_done, tx_done, busy, rx_ready, tx_ready} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {enable_1, enable_0, txnrx_1, txnrx_0, tdd_sync_o, rx_done, tx_done, busy, rx_ready, tx_ready});
      end
      @(posedge axi_aclk); #1;
      arst = 1'b0;
      @(posedge axi_aclk); #1;
      rx_valid = 1'b1; tx_valid = 1'b1;
      #1;
      vectors++;
      if ({rx_ready, tx_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_priority: ready rx/tx %b expected 10", {rx_ready, tx_ready});
      end
      rx_valid = 1'b0;
      #1;
      vectors++;
      if ({rx_ready, tx_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL single_tx_ready: ready rx/tx %b expected 01", {rx_ready, tx_ready});
      end
      tx_valid = 1'b0;
   endtask

   task automatic test_contention();
      int n = 0;
      int k = 0;
      bit ok, d;
      for (int i = 0; i < 4; i++) begin
         d = b_prio;
         push(d, 2'b11, d ? 7 : 5);
      end
      @(posedge axi_aclk); #1;
      rx_len = 5; tx_len = 7; rx_mask = 2'b11; tx_mask = 2'b11;
      rx_valid = 1'b1; tx_valid = 1'b1;
      while (n < 4 && k < 400) begin
         @(negedge axi_aclk);
         k++;
         if ((rx_valid && rx_ready) || (tx_valid && tx_ready)) n++;
      end
      @(posedge axi_aclk); #1;
      rx_valid = 1'b0; tx_valid = 1'b0;
      wait_idle(200, ok);
      vectors++;
      if (n !== 4 || !ok) begin
         miscompares++;
         $display("FAIL contention_timeout: grants %0d expected 4, idle %0d", n, ok);
      end
   endtask

   task automatic test_single_rx();
      bit ok1, ok2;
      send(1'b0, 2'b11, 16'd10, 10, ok1);
      wait_idle(100, ok2);
      vectors++;
      if (!(ok1 && ok2)) begin
         miscompares++;
         $display("FAIL single_rx_timeout: accept %0d idle %0d expected 1 1", ok1, ok2);
      end
   endtask

   task automatic test_mask();
      bit ok1, ok2;
      send(1'b1, 2'b10, 16'd3, 3, ok1);
      wait_idle(100, ok2);
      vectors++;
      if (!(ok1 && ok2)) begin
         miscompares++;
         $display("FAIL mask_timeout: accept %0d idle %0d expected 1 1", ok1, ok2);
      end
   endtask

   task automatic test_len_zero();
      bit ok1, ok2;
      send(1'b0, 2'b11, 16'd0, 1, ok1);
      wait_idle(100, ok2);
      vectors++;
      if (!(ok1 && ok2)) begin
         miscompares++;
         $display("FAIL len_zero_timeout: accept %0d idle %0d expected 1 1", ok1, ok2);
      end
   endtask

   task automatic test_abort();
      bit ok1, ok2, ok3;
      send(1'b1, 2'b11, 16'd100, 3, ok1);
      wait_sync(ok2);
      @(posedge axi_aclk); #1;
      @(posedge axi_aclk); #1;
      abort = 1'b1;
      @(posedge axi_aclk); #1;
      abort = 1'b0;
      wait_idle(100, ok3);
      vectors++;
      if (!(ok1 && ok2 && ok3)) begin
         miscompares++;
         $display("FAIL abort_timeout: accept %0d sync %0d idle %0d expected 1 1 1", ok1, ok2, ok3);
      end
   endtask

   task automatic test_mask_zero_abort_guard();
      bit ok1, ok2, ok3;
      send(1'b0, 2'b00, 16'd4, 4, ok1);
      ok2 = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge axi_aclk);
         if (rx_done) begin ok2 = 1'b1; break; end
      end
      @(posedge axi_aclk); #1;
      abort = 1'b1;
      @(posedge axi_aclk); #1;
      abort = 1'b0;
      wait_idle(100, ok3);
      vectors++;
      if (!(ok1 && ok2 && ok3)) begin
         miscompares++;
         $display("FAIL mask_zero_timeout: accept %0d done %0d idle %0d expected 1 1 1", ok1, ok2, ok3);
      end
   endtask

   task automatic test_back_to_back();
      int acc[2];
      int n = 0;
      int k = 0;
      bit ok;
      push(1'b0, 2'b11, 6);
      push(1'b0, 2'b11, 6);
      @(posedge axi_aclk); #1;
      rx_len = 6; rx_mask = 2'b11; rx_valid = 1'b1;
      while (n < 2 && k < 200) begin
         @(negedge axi_aclk);
         k++;
         if (rx_ready) begin acc[n] = cyc; n++; end
      end
      @(posedge axi_aclk); #1;
      rx_valid = 1'b0;
      wait_idle(100, ok);
      vectors++;
      if (n !== 2 || !ok || acc[1] - acc[0] !== S + 6 + G + 1) begin
         miscompares++;
         $display("FAIL back_to_back: grants %0d spacing %0d expected 2 %0d", n,
                  (n == 2) ? acc[1] - acc[0] : -1, S + 6 + G + 1);
      end
   endtask

   task automatic test_reset_mid();
      bit ok1, ok2, ok3, ok4;
      int bad_done = 0;
      send(1'b1, 2'b11, 16'd4, 4, ok1);
      wait_idle(100, ok2);
      send(1'b0, 2'b10, 16'd50, 50, ok3);
      wait_sync(ok4);
      @(posedge axi_aclk); #1;
      @(posedge axi_aclk); #2;
      vectors++;
      if ({enable_1, enable_0, txnrx_1, txnrx_0, busy} !== 5'b10011) begin
         miscompares++;
         $display("FAIL pre_reset_pins: got %b expected 10011", {enable_1, enable_0, txnrx_1, txnrx_0, busy});
      end
      arst = 1'b1;
      #1;
      vectors++;
      if ({enable_1, enable_0, txnrx_1, txnrx_0, busy} !== 5'b00000) begin
         miscompares++;
         $display("FAIL async_reset_drop: got %b expected 00000", {enable_1, enable_0, txnrx_1, txnrx_0, busy});
      end
      q.delete();
      b_prio = 1'b0;
      b_txnrx = 2'b00;
      repeat (2) begin @(negedge axi_aclk); if (rx_done || tx_done) bad_done++; end
      @(posedge axi_aclk); #1;
      arst = 1'b0;
      repeat (3) begin @(negedge axi_aclk); if (rx_done || tx_done) bad_done++; end
      vectors++;
      if (bad_done !== 0 || !(ok1 && ok2 && ok3 && ok4)) begin
         miscompares++;
         $display("FAIL reset_no_done: done pulses %0d expected 0, setup ok %0d%0d%0d%0d",
                  bad_done, ok1, ok2, ok3, ok4);
      end
      push(b_prio, 2'b11, 2);
      @(posedge axi_aclk); #1;
      rx_len = 2; tx_len = 2; rx_mask = 2'b11; tx_mask = 2'b11;
      rx_valid = 1'b1; tx_valid = 1'b1;
      #1;
      vectors++;
      if ({rx_ready, tx_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL post_reset_priority: ready rx/tx %b expected 10", {rx_ready, tx_ready});
      end
      @(posedge axi_aclk); #1;
      rx_valid = 1'b0; tx_valid = 1'b0;
      wait_idle(100, ok1);
      vectors++;
      if (!ok1) begin
         miscompares++;
         $display("FAIL post_reset_timeout: idle %0d expected 1", ok1);
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_rx();
      test_mask();
      test_len_zero();
      test_abort();
      test_mask_zero_abort_guard();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge axi_aclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
